// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
//  Shares the single cache/memory port between the pipeline data stage (D),
//  the pipeline fetch stage (F) and the input-device store path (IO).
//  Fixed priority D > F > IO; each granted request performs exactly one
//  registered memory access, aborted with an err pulse if mem_ack does not
//  arrive within TIMEOUT_CYC access cycles (0 disables the timeout).
//
//  Optional feature macro: ARB_STARVE_GUARD_EN
//   When defined, a starve counter lets IO win the arbitration after it has
//   lost STARVE_LIM grants in a row to D/F. When undefined, strict priority.
//
//  Ports
//   g_clk, g_clr            clock, synchronous active-high reset
//   d_req/d_we/d_addr/d_wdata   data-stage request (read or write)
//   f_req/f_addr            fetch request (always a read)
//   io_req/io_addr/io_wdata store request from the input device (always a write)
//   mem_sel/mem_we/mem_addr/mem_wdata  memory access, held until ack/abort
//   mem_rdata/mem_ack       memory response
//   grant[2:0]              one-hot owner {io,f,d}, 000 when idle
//   done[2:0]               one-cycle completion pulse {io,f,d}
//   rdata                   read data captured at ack (0x00 after a timeout)
//   err                     one-cycle pulse on timeout abort
module mem_port_arbiter #(
  parameter int TIMEOUT_CYC = 16,
  parameter int STARVE_LIM  = 4
) (
  input  logic       g_clk,
  input  logic       g_clr,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  input  logic       f_req,
  input  logic [7:0] f_addr,
  input  logic       io_req,
  input  logic [7:0] io_addr,
  input  logic [7:0] io_wdata,
  output logic       mem_sel,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic [7:0] rdata,
  output logic       err
);

  // Counter only has to hold 0 .. TIMEOUT_CYC-1.
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic          mem_sel_reg, mem_sel_next;
  logic          mem_we_reg, mem_we_next;
  logic [7:0]    mem_addr_reg, mem_addr_next;
  logic [7:0]    mem_wdata_reg, mem_wdata_next;
  logic [2:0]    grant_reg, grant_next;
  logic [2:0]    done_reg, done_next;
  logic [7:0]    rdata_reg, rdata_next;
  logic          err_reg, err_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;

  logic [2:0]    pick;      // one-hot arbitration winner {io,f,d}
  logic          io_force;  // IO overrides the fixed priority
  logic          tmo_hit;   // last allowed access cycle without ack

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt_reg, starve_cnt_next;

  assign io_force = io_req && (starve_cnt_reg == 3'(STARVE_LIM));

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!io_req) begin
      starve_cnt_next = 3'd0;
    end else if (state_reg == S_IDLE) begin
      if (pick[2]) begin
        starve_cnt_next = 3'd0;
      end else if ((pick[1] || pick[0]) && (starve_cnt_reg != 3'd7)) begin
        starve_cnt_next = starve_cnt_reg + 3'd1;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      starve_cnt_reg <= 3'd0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end
`else
  // Without the guard the limit has no effect; IO may starve.
  assign io_force = 1'b0 && (STARVE_LIM > 0);
`endif

  always_comb begin
    pick = 3'b000;
    if (io_force) begin
      pick = 3'b100;
    end else if (d_req) begin
      pick = 3'b001;
    end else if (f_req) begin
      pick = 3'b010;
    end else if (io_req) begin
      pick = 3'b100;
    end
  end

  assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));

  // State register
  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:   if (pick != 3'b000) state_next = S_ACCESS;
      S_ACCESS: if (mem_ack || tmo_hit) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    mem_sel_next   = mem_sel_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    grant_next     = grant_reg;
    done_next      = 3'b000;
    rdata_next     = rdata_reg;
    err_next       = 1'b0;
    tmo_cnt_next   = tmo_cnt_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (pick != 3'b000) begin
          grant_next   = pick;
          mem_sel_next = 1'b1;
          tmo_cnt_next = '0;
          if (pick[0]) begin
            mem_we_next    = d_we;
            mem_addr_next  = d_addr;
            mem_wdata_next = d_wdata;
          end else if (pick[1]) begin
            mem_we_next    = 1'b0;
            mem_addr_next  = f_addr;
            mem_wdata_next = 8'h00;
          end else begin
            mem_we_next    = 1'b1;
            mem_addr_next  = io_addr;
            mem_wdata_next = io_wdata;
          end
        end
      end
      S_ACCESS: begin
        // An ack on the timeout edge still counts as a normal completion.
        if (mem_ack) begin
          mem_sel_next = 1'b0;
          done_next    = grant_reg;
          if (!mem_we_reg) rdata_next = mem_rdata;
        end else if (tmo_hit) begin
          mem_sel_next = 1'b0;
          done_next    = grant_reg;
          err_next     = 1'b1;
          rdata_next   = 8'h00;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end
      end
      S_DONE: begin
        grant_next = 3'b000;
      end
      default: begin
        mem_sel_next = 1'b0;
        grant_next   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      mem_sel_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 8'h00;
      mem_wdata_reg <= 8'h00;
      grant_reg     <= 3'b000;
      done_reg      <= 3'b000;
      rdata_reg     <= 8'h00;
      err_reg       <= 1'b0;
      tmo_cnt_reg   <= '0;
    end else begin
      mem_sel_reg   <= mem_sel_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      grant_reg     <= grant_next;
      done_reg      <= done_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
      tmo_cnt_reg   <= tmo_cnt_next;
    end
  end

  assign mem_sel   = mem_sel_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign grant     = grant_reg;
  assign done      = done_reg;
  assign rdata     = rdata_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Testbench for mem_port_arbiter: directed requests, a memory responder with
// programmable ack delay, and a scoreboard monitor that checks every done pulse.
module tb_mem_port_arbiter;

  logic       g_clk = 1'b0;
  logic       g_clr;
  logic       d_req, d_we, f_req, io_req;
  logic [7:0] d_addr, d_wdata, f_addr, io_addr, io_wdata;
  logic       mem_sel, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, rdata;
  logic [2:0] grant, done;
  logic       err;

  mem_port_arbiter #(.TIMEOUT_CYC(16), .STARVE_LIM(4)) dut (
    .g_clk(g_clk), .g_clr(g_clr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .f_req(f_req), .f_addr(f_addr),
    .io_req(io_req), .io_addr(io_addr), .io_wdata(io_wdata),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .grant(grant), .done(done), .rdata(rdata), .err(err)
  );

  initial forever #5 g_clk = ~g_clk;

  typedef struct {
    logic [2:0] done;
    logic       err;
    logic [7:0] rdata;
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;
  int   cyc       = 0;
  int   done_cyc[$];
  logic ack_en    = 1'b1;
  int   ack_delay = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
  endtask

  task automatic push(input logic [2:0] d, input logic e, input logic [7:0] rd,
                      input logic [7:0] a, input logic w, input logic [7:0] wd);
    exp_t x;
    x.done = d; x.err = e; x.rdata = rd; x.addr = a; x.we = w; x.wdata = wd;
    exp_q.push_back(x);
  endtask

  initial forever begin
    @(posedge g_clk);
    cyc++;
  end

  // Memory responder: acks ack_delay cycles into an access; rdata = addr ^ 0x39.
  initial begin
    int sel_cnt;
    sel_cnt   = 0;
    mem_ack   = 1'b0;
    mem_rdata = 8'hEE;
    forever begin
      @(negedge g_clk);
      if (mem_sel) begin
        if (ack_en && sel_cnt == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_addr ^ 8'h39;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 8'hEE;
        end
        sel_cnt++;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'hEE;
        sel_cnt   = 0;
      end
    end
  end

  // Scoreboard monitor
  initial forever begin
    @(negedge g_clk);
    if (done != 3'b000 || err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {28'd0, err, done}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn cyc=%0d done=%b err=%b addr=0x%02h we=%b rdata=0x%02h",
                 cyc, done, err, mem_addr, mem_we, rdata);
        chk("done", done, e.done);
        chk("grant", grant, e.done);
        chk("err", err, e.err);
        chk("rdata", rdata, e.rdata);
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", mem_we, e.we);
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
      end
    end
  end

  // Requester model: waits for n done pulses, dropping each non-held request
  // once its done is seen, then releases everything and lets the FSM settle.
  task automatic run(input int n, input int budget, input logic [2:0] hold);
    int seen = 0;
    int t = 0;
    done_cyc.delete();
    while (seen < n && t < budget) begin
      @(negedge g_clk);
      t++;
      if (done != 3'b000) begin
        done_cyc.push_back(cyc);
        seen++;
        if (done[0] && !hold[0]) d_req = 1'b0;
        if (done[1] && !hold[1]) f_req = 1'b0;
        if (done[2] && !hold[2]) io_req = 1'b0;
      end
    end
    if (seen < n) chk("done_budget", seen, n);
    d_req = 1'b0; f_req = 1'b0; io_req = 1'b0;
    repeat (2) @(negedge g_clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    g_clr = 1'b1;
    d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 8'h00;
    f_req = 1'b0; f_addr = 8'h00;
    io_req = 1'b0; io_addr = 8'h00; io_wdata = 8'h00;
    repeat (3) @(negedge g_clk);
    chk("rst_mem_sel", mem_sel, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    g_clr = 1'b0;
    @(negedge g_clk);

    // 1: single D read with ack in the first access cycle
    push(3'b001, 1'b0, 8'h3C, 8'h05, 1'b0, 8'h00);
    d_we = 1'b0; d_addr = 8'h05; d_req = 1'b1;
    start = cyc;
    @(negedge g_clk);
    chk("t1_mem_sel", mem_sel, 1);
    chk("t1_grant", grant, 3'b001);
    run(1, 20, 3'b000);
    if (done_cyc.size() > 0) chk("t1_latency", done_cyc[0] - start, 2);

    // 2: all three at once -> d, f, io, 3 cycles apart
    push(3'b001, 1'b0, 8'h28, 8'h11, 1'b0, 8'h00);
    push(3'b010, 1'b0, 8'h1B, 8'h22, 1'b0, 8'h00);
    push(3'b100, 1'b0, 8'h1B, 8'h33, 1'b1, 8'h5A);
    d_addr = 8'h11; f_addr = 8'h22; io_addr = 8'h33; io_wdata = 8'h5A;
    d_req = 1'b1; f_req = 1'b1; io_req = 1'b1;
    run(3, 40, 3'b000);
    if (done_cyc.size() == 3) begin
      chk("t2_gap_df", done_cyc[1] - done_cyc[0], 3);
      chk("t2_gap_fio", done_cyc[2] - done_cyc[1], 3);
    end

    // 4: IO write with delayed ack; rdata must keep the previous read value
    ack_delay = 3;
    push(3'b100, 1'b0, 8'h1B, 8'h07, 1'b1, 8'h0A);
    io_addr = 8'h07; io_wdata = 8'h0A; io_req = 1'b1;
    run(1, 30, 3'b000);

    // 3: F read that never gets an ack -> timeout after 16 access cycles
    ack_en = 1'b0;
    push(3'b010, 1'b1, 8'h00, 8'h44, 1'b0, 8'h00);
    f_addr = 8'h44; f_req = 1'b1;
    start = cyc;
    run(1, 40, 3'b000);
    if (done_cyc.size() > 0) chk("t3_latency", done_cyc[0] - start, 17);
    ack_en = 1'b1; ack_delay = 0;

    // 5: reset in the middle of an access, then normal service
    ack_en = 1'b0;
    d_addr = 8'h55; d_req = 1'b1;
    repeat (3) @(negedge g_clk);
    chk("t5_busy", mem_sel, 1);
    g_clr = 1'b1; d_req = 1'b0;
    @(negedge g_clk);
    chk("t5_mem_sel", mem_sel, 0);
    chk("t5_grant", grant, 0);
    chk("t5_done", done, 0);
    chk("t5_err", err, 0);
    g_clr = 1'b0; ack_en = 1'b1; ack_delay = 0;
    @(negedge g_clk);
    push(3'b001, 1'b0, 8'h3C, 8'h05, 1'b0, 8'h00);
    d_addr = 8'h05; d_req = 1'b1;
    run(1, 20, 3'b000);

    // 6: D held continuously with IO waiting
    d_addr = 8'h40; d_we = 1'b0; io_addr = 8'h07; io_wdata = 8'h0A;
`ifdef ARB_STARVE_GUARD_EN
    for (int i = 0; i < 4; i++) push(3'b001, 1'b0, 8'h79, 8'h40, 1'b0, 8'h00);
    push(3'b100, 1'b0, 8'h79, 8'h07, 1'b1, 8'h0A);
    d_req = 1'b1; io_req = 1'b1;
    run(5, 60, 3'b001);
`else
    for (int i = 0; i < 6; i++) push(3'b001, 1'b0, 8'h79, 8'h40, 1'b0, 8'h00);
    d_req = 1'b1; io_req = 1'b1;
    run(6, 60, 3'b001);
`endif

    repeat (3) @(negedge g_clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
